// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with one
// 32-bit word per line. A miss stalls the core through Dhit until it is
// serviced over a single-word req/ack handshake to backing memory.
module dcache_wb #(
   parameter int LINES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dcen,
   input  logic        MemWrite,
   input  logic [31:0] DataAddr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Dhit,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int INDEX_BITS = $clog2(LINES);
   localparam int TAG_BITS   = 30 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      REFILL = 2'd2
   } stateT;

   stateT state;
   stateT nextState;

   logic [LINES-1:0]    validArr;
   logic [LINES-1:0]    dirtyArr;
   logic [TAG_BITS-1:0] tagArr  [LINES];
   logic [31:0]         dataArr [LINES];

   logic [INDEX_BITS-1:0] reqIdx;
   logic [TAG_BITS-1:0]   reqTag;
   logic [INDEX_BITS-1:0] missIdx;
   logic [TAG_BITS-1:0]   missTag;
   logic                  hit;
   logic                  storeHit;
   logic                  wbDone;
   logic                  refillDone;
   logic                  unusedAddrBits;

   // Byte-offset bits are irrelevant for word-only accesses.
   assign unusedAddrBits = ^DataAddr[1:0];

   assign reqIdx = DataAddr[1+INDEX_BITS:2];
   assign reqTag = DataAddr[31:2+INDEX_BITS];
   assign hit    = dcen & validArr[reqIdx] & (tagArr[reqIdx] == reqTag);

   // State register; async reset abandons any in-flight handshake at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: one state step per mem_ack, no abort path.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (dcen && !hit) begin
               if (validArr[reqIdx] && dirtyArr[reqIdx]) begin
                  nextState = WB;
               end else begin
                  nextState = REFILL;
               end
            end else begin
               nextState = IDLE;
            end
         end
         WB: begin
            if (mem_ack) begin
               nextState = REFILL;
            end else begin
               nextState = WB;
            end
         end
         REFILL: begin
            if (mem_ack) begin
               nextState = IDLE;
            end else begin
               nextState = REFILL;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Output logic: core-side response, memory request and array update strobes.
   always_comb begin
      Dhit       = 1'b1;
      ReadData   = 32'h0000_0000;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0000_0000;
      mem_wdata  = 32'h0000_0000;
      storeHit   = 1'b0;
      wbDone     = 1'b0;
      refillDone = 1'b0;
      if (reset) begin
         Dhit = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               Dhit     = ~dcen | hit;
               storeHit = hit & MemWrite;
               if (hit && !MemWrite) begin
                  ReadData = dataArr[reqIdx];
               end else begin
                  ReadData = 32'h0000_0000;
               end
            end
            WB: begin
               Dhit      = 1'b0;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {tagArr[missIdx], missIdx, 2'b00};
               mem_wdata = dataArr[missIdx];
               wbDone    = mem_ack;
            end
            REFILL: begin
               Dhit       = 1'b0;
               mem_req    = 1'b1;
               mem_we     = 1'b0;
               mem_addr   = {missTag, missIdx, 2'b00};
               refillDone = mem_ack;
            end
            default: begin
               Dhit = 1'b1;
            end
         endcase
      end
   end

   // Capture the missing address so the memory side stays stable through the miss.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         missIdx <= {INDEX_BITS{1'b0}};
         missTag <= {TAG_BITS{1'b0}};
      end else if (state == IDLE && dcen && !hit) begin
         missIdx <= reqIdx;
         missTag <= reqTag;
      end else begin
         missIdx <= missIdx;
         missTag <= missTag;
      end
   end

   // Valid/dirty bookkeeping; cleared on reset so dirty data is deliberately dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         validArr <= {LINES{1'b0}};
         dirtyArr <= {LINES{1'b0}};
      end else begin
         if (storeHit) begin
            dirtyArr[reqIdx] <= 1'b1;
         end
         if (wbDone) begin
            dirtyArr[missIdx] <= 1'b0;
         end
         if (refillDone) begin
            validArr[missIdx] <= 1'b1;
            dirtyArr[missIdx] <= 1'b0;
         end
      end
   end

   // Tag and data storage; contents are don't-care until the valid bit is set.
   always_ff @(posedge clk) begin
      if (storeHit) begin
         dataArr[reqIdx] <= WriteData;
      end
      if (refillDone) begin
         dataArr[missIdx] <= mem_rdata;
         tagArr[missIdx]  <= missTag;
      end
   end

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: scoreboard bench for dcache_wb. Expected memory transactions
// and load data are queued when an access is issued and compared as the DUT
// produces them; a small associative array stands in for backing memory.
module tb_dcache_wb;

   logic        clk;
   logic        reset;
   logic        dcen;
   logic        MemWrite;
   logic [31:0] DataAddr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Dhit;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txnT;

   txnT         expMem  [$];
   logic [31:0] expLoad [$];
   logic [31:0] backMem [logic [31:0]];

   int passCnt  = 0;
   int totalCnt = 0;

   dcache_wb #(.LINES(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .dcen      (dcen),
      .MemWrite  (MemWrite),
      .DataAddr  (DataAddr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Dhit      (Dhit),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic txnT mkTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      txnT t;
      t.we = we;
      t.addr = addr;
      t.wdata = wdata;
      return t;
   endfunction

   // Issue one access, act as backing memory with the given ack latency,
   // and check memory transactions, load data and the number of stall cycles.
   task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input int expStalls, input string name);
      int   reqCycles;
      int   stalls;
      bit   done;
      bit   haveCur;
      txnT  cur;
      logic [31:0] want;
      reqCycles = 0;
      stalls    = 0;
      done      = 1'b0;
      haveCur   = 1'b0;
      @(negedge clk);
      dcen      = 1'b1;
      MemWrite  = we;
      DataAddr  = addr;
      WriteData = wdata;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         #1;
         if (mem_req === 1'b1) begin
            if (!haveCur) begin
               if (expMem.size() == 0) begin
                  totalCnt++;
                  $display("FAIL %s unexpected_req: got we=%b addr=%h, required no request", name, mem_we, mem_addr);
               end else begin
                  cur = expMem.pop_front();
                  haveCur = 1'b1;
               end
            end
            if (haveCur) begin
               totalCnt++;
               if (mem_we !== cur.we || mem_addr !== cur.addr || (cur.we && mem_wdata !== cur.wdata))
                  $display("FAIL %s mem_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                           name, mem_we, mem_addr, mem_wdata, cur.we, cur.addr, cur.wdata);
               else
                  passCnt++;
            end
            if (reqCycles == lat) begin
               mem_ack = 1'b1;
               if (mem_we === 1'b1) begin
                  backMem[mem_addr] = mem_wdata;
                  mem_rdata = 32'h0000_0000;
               end else if (backMem.exists(mem_addr)) begin
                  mem_rdata = backMem[mem_addr];
               end else begin
                  mem_rdata = 32'h0000_0000;
               end
               reqCycles = 0;
               haveCur = 1'b0;
            end else begin
               reqCycles++;
            end
         end else begin
            reqCycles = 0;
         end
         if (Dhit === 1'b1) begin
            done = 1'b1;
            if (!we) begin
               totalCnt++;
               if (expLoad.size() == 0) begin
                  $display("FAIL %s load_data: got %h, required nothing queued", name, ReadData);
               end else begin
                  want = expLoad.pop_front();
                  if (ReadData !== want)
                     $display("FAIL %s load_data: got %h, required %h", name, ReadData, want);
                  else
                     passCnt++;
               end
            end
         end else begin
            stalls++;
         end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      dcen     = 1'b0;
      MemWrite = 1'b0;
      totalCnt++;
      if (!done)
         $display("FAIL %s timeout: got Dhit=%b after 60 cycles, required 1", name, Dhit);
      else
         passCnt++;
      totalCnt++;
      if (stalls != expStalls)
         $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, expStalls);
      else
         passCnt++;
      totalCnt++;
      if (expMem.size() != 0)
         $display("FAIL %s missing_txn: got %0d outstanding, required 0", name, expMem.size());
      else
         passCnt++;
      expMem.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dcen = 1'b1;
      MemWrite = 1'b0;
      DataAddr = 32'h0000_0100;
      WriteData = 32'h0000_0000;
      mem_ack = 1'b0;
      mem_rdata = 32'h0000_0000;
      repeat (2) @(negedge clk);
      totalCnt++;
      if (Dhit !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || ReadData !== 32'h0)
         $display("FAIL reset_outputs: got Dhit=%b req=%b we=%b rd=%h, required 1 0 0 0", Dhit, mem_req, mem_we, ReadData);
      else
         passCnt++;
      reset = 1'b0;
      dcen = 1'b0;
   endtask

   task automatic test_clean_load_miss();
      backMem[32'h0000_0100] = 32'hDEAD_BEEF;
      expMem.push_back(mkTxn(1'b0, 32'h0000_0100, 32'h0));
      expLoad.push_back(32'hDEAD_BEEF);
      doAccess(1'b0, 32'h0000_0100, 32'h0, 3, 5, "t1_load_miss");
   endtask

   task automatic test_store_hit();
      doAccess(1'b1, 32'h0000_0100, 32'h1234_5678, 1, 0, "t2_store_hit");
      expLoad.push_back(32'h1234_5678);
      doAccess(1'b0, 32'h0000_0100, 32'h0, 1, 0, "t2_load_hit");
   endtask

   task automatic test_dirty_evict();
      backMem[32'h0000_0200] = 32'h0BAD_F00D;
      expMem.push_back(mkTxn(1'b1, 32'h0000_0100, 32'h1234_5678));
      expMem.push_back(mkTxn(1'b0, 32'h0000_0200, 32'h0));
      expLoad.push_back(32'h0BAD_F00D);
      doAccess(1'b0, 32'h0000_0200, 32'h0, 1, 5, "t3_dirty_miss");
      totalCnt++;
      if (backMem[32'h0000_0100] !== 32'h1234_5678)
         $display("FAIL t3_wb_data: got %h, required %h", backMem[32'h0000_0100], 32'h1234_5678);
      else
         passCnt++;
   endtask

   task automatic test_store_miss();
      backMem[32'h0000_0304] = 32'h1111_1111;
      expMem.push_back(mkTxn(1'b0, 32'h0000_0304, 32'h0));
      doAccess(1'b1, 32'h0000_0304, 32'hA5A5_A5A5, 2, 4, "t4_store_miss");
      backMem[32'h0000_0404] = 32'h2222_2222;
      expMem.push_back(mkTxn(1'b1, 32'h0000_0304, 32'hA5A5_A5A5));
      expMem.push_back(mkTxn(1'b0, 32'h0000_0404, 32'h0));
      expLoad.push_back(32'h2222_2222);
      doAccess(1'b0, 32'h0000_0404, 32'h0, 2, 7, "t4_conflict");
   endtask

   task automatic test_back_to_back();
      backMem[32'h0000_0500] = 32'h5555_0500;
      expMem.push_back(mkTxn(1'b0, 32'h0000_0500, 32'h0));
      expLoad.push_back(32'h5555_0500);
      doAccess(1'b0, 32'h0000_0500, 32'h0, 0, 2, "t5_ack0_clean");
      doAccess(1'b1, 32'h0000_0500, 32'hBEEF_0500, 0, 0, "t5_store");
      backMem[32'h0000_0600] = 32'h6666_0600;
      expMem.push_back(mkTxn(1'b1, 32'h0000_0500, 32'hBEEF_0500));
      expMem.push_back(mkTxn(1'b0, 32'h0000_0600, 32'h0));
      expLoad.push_back(32'h6666_0600);
      doAccess(1'b0, 32'h0000_0600, 32'h0, 0, 3, "t5_ack0_dirty");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ack = 1'b1;
         mem_rdata = 32'hFFFF_FFFF;
         #1;
         totalCnt++;
         if (mem_req !== 1'b0 || Dhit !== 1'b1)
            $display("FAIL t5_idle_ack: got req=%b Dhit=%b, required 0 1", mem_req, Dhit);
         else
            passCnt++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      expLoad.push_back(32'h6666_0600);
      doAccess(1'b0, 32'h0000_0600, 32'h0, 0, 0, "t5_after_idle_ack");
   endtask

   task automatic test_reset_mid_wb();
      bit seen;
      doAccess(1'b1, 32'h0000_0600, 32'hCAFE_0006, 0, 0, "t6_store");
      seen = 1'b0;
      @(negedge clk);
      dcen = 1'b1;
      MemWrite = 1'b0;
      DataAddr = 32'h0000_0100;
      for (int i = 0; i < 10 && !seen; i++) begin
         #1;
         if (mem_req === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      totalCnt++;
      if (!seen || mem_we !== 1'b1 || mem_addr !== 32'h0000_0600)
         $display("FAIL t6_wb_start: got req=%b we=%b addr=%h, required 1 1 00000600", mem_req, mem_we, mem_addr);
      else
         passCnt++;
      reset = 1'b1;
      #1;
      totalCnt++;
      if (mem_req !== 1'b0 || Dhit !== 1'b1)
         $display("FAIL t6_async_drop: got req=%b Dhit=%b, required 0 1", mem_req, Dhit);
      else
         passCnt++;
      @(negedge clk);
      reset = 1'b0;
      dcen = 1'b0;
      expMem.push_back(mkTxn(1'b0, 32'h0000_0100, 32'h0));
      expLoad.push_back(32'h1234_5678);
      doAccess(1'b0, 32'h0000_0100, 32'h0, 2, 4, "t6_after_reset");
   endtask

   initial begin
      test_reset();
      test_clean_load_miss();
      test_store_hit();
      test_dirty_evict();
      test_store_miss();
      test_back_to_back();
      test_reset_mid_wb();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
